// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit with a single outstanding memory request
// and a 2-entry in-order buffer feeding the decode stage.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   ce, pc            fetch enable and next fetch address from the PC register
//   pc_advance        same-cycle pulse: pc consumed, PC register may step
//   imem_req/addr     registered memory request (held until imem_ack)
//   imem_ack/rdata    memory response
//   flush             redirect: discard buffered and in-flight fetches
//   id_valid/ready    decode handshake
//   id_pc/inst/misal  head entry of the buffer
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] pc,
  output logic        pc_advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_misalign
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            misalign;
  } entry_t;

  state_t          state;
  logic            drop;
  logic [XLEN-1:0] req_pc;
  entry_t          fifo_q [DEPTH];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;

  logic            issue;
  logic            misalign;
  logic            push_mis;
  logic            push_ack;
  logic            push;
  logic            pop;
  entry_t          push_data;

  // Issue decision; gated by rst so nothing is consumed while in reset.
  always_comb begin
    misalign  = |pc[1:0];
    issue     = rst && ce && !flush && (state == S_IDLE) && (count != 2'd2);
    push_mis  = issue && misalign;
    // A flush in the ack cycle discards the returning word directly.
    push_ack  = (state == S_WAIT) && imem_ack && !drop && !flush;
    push      = push_mis || push_ack;
    pop       = id_valid && id_ready;
    push_data = push_mis ? entry_t'{pc: pc, inst: '0, misalign: 1'b1}
                         : entry_t'{pc: req_pc, inst: imem_rdata, misalign: 1'b0};
  end

  assign pc_advance  = issue;
  assign id_valid    = (count != 2'd0);
  assign id_pc       = fifo_q[rd_ptr].pc;
  assign id_inst     = fifo_q[rd_ptr].inst;
  assign id_misalign = fifo_q[rd_ptr].misalign;

  // Request FSM and output buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      drop      <= 1'b0;
      req_pc    <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue && !misalign) begin
            state     <= S_WAIT;
            imem_req  <= 1'b1;
            imem_addr <= pc;
            req_pc    <= pc;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            state    <= S_IDLE;
            imem_req <= 1'b0;
            drop     <= 1'b0;
          end else if (flush) begin
            // Request stays on the bus until acked; its data is discarded.
            drop <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Flush wins over push and pop.
      if (flush) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr] <= push_data;
          wr_ptr         <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-low reset; rst=0 sampled at a rising clk edge resets the block.
REQ-003 ce  input  1  fetch enable from the PC register; 0 = no new fetch issued.
REQ-004 pc  input  32  address of the next instruction to fetch.
REQ-005 pc_advance  output  1  one-cycle pulse; the current pc has been consumed and the PC register may step.
REQ-006 imem_req  output  1  instruction-memory request; registered.
REQ-007 imem_addr  output  32  word-aligned request address; registered.
REQ-008 imem_ack  input  1  memory response valid; qualifies imem_rdata.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 flush  input  1  discards all buffered and in-flight fetches (branch/jump redirect).
REQ-011 id_valid  output  1  decode-stage entry available.
REQ-012 id_ready  input  1  decode stage accepts the entry.
REQ-013 id_pc  output  32  pc of the head entry.
REQ-014 id_inst  output  32  instruction of the head entry.
REQ-015 id_misalign  output  1  head entry came from a pc with pc[1:0] != 0.

Function
REQ-016 The block SHALL implement a 2-state FSM, IDLE and WAIT, and a 2-entry in-order output FIFO of {pc, inst, misalign}.
REQ-017 Issue: in IDLE, when ce=1, flush=0, FIFO count<=1 and pc[1:0]=0, the block SHALL pulse pc_advance, latch pc into req_pc, and enter WAIT with imem_req=1 and imem_addr=pc in the next cycle.
REQ-018 Misaligned pc: in IDLE, under the same conditions but with pc[1:0]!=0, the block SHALL pulse pc_advance, push {pc, 32'h0, 1} directly into the FIFO, issue no memory request, and remain in IDLE.
REQ-019 In WAIT, imem_req and imem_addr SHALL hold stable until the cycle in which imem_ack=1; imem_ack may arrive in the first WAIT cycle.
REQ-020 On imem_ack in WAIT, the block SHALL push {req_pc, imem_rdata, 0} into the FIFO unless the drop flag is set, deassert imem_req next cycle, clear drop, and return to IDLE.
REQ-021 imem_ack outside WAIT SHALL be ignored.
REQ-022 Latency: an ack in cycle N SHALL make the entry visible on id_* in cycle N+1; peak throughput is one instruction per 2 cycles.
REQ-023 id_valid SHALL equal (count!=0), and id_pc, id_inst and id_misalign SHALL present the head entry.
REQ-024 The head entry SHALL be popped when id_valid & id_ready; a pop and a push in the same cycle SHALL leave count unchanged and preserve order.
REQ-025 The FIFO SHALL never overflow: issue requires count<=1 and at most one request is outstanding.
REQ-026 Flush: the block SHALL set count to 0 in the next cycle and suppress any issue or pc_advance that cycle.
REQ-027 A flush while in WAIT, or in the same cycle as imem_ack, SHALL set drop (or discard directly), so the returning instruction is never pushed.
REQ-028 Flush has priority over push and pop in the same cycle.
REQ-029 pc_advance SHALL be 0 whenever ce=0, flush=1, the FSM is in WAIT, or count=2.
REQ-030 FIFO pointers SHALL wrap modulo 2; count is a 2-bit value in the range 0..2.

Reset
REQ-031 While rst=0 at a clock edge, the block SHALL next hold: state=IDLE, count=0, pointers=0, drop=0, imem_req=0, imem_addr=0, pc_advance=0, id_valid=0, id_pc=0, id_inst=0, id_misalign=0.
REQ-032 A reset asserted during WAIT SHALL abandon the outstanding request; a late imem_ack after reset SHALL be ignored.
REQ-033 After rst returns to 1, the first issue SHALL occur no earlier than the first cycle with ce=1.

Verification
REQ-034 Basic fetch: pc=0x0, ce=1, ack one cycle after imem_req with rdata=0x8C010004, id_ready=1 -> id_valid=1 with id_pc=0x0, id_inst=0x8C010004, then pc_advance pulses for pc=0x4.
REQ-035 Backpressure: id_ready=0, zero-wait acks, pcs 0x0, 0x4, 0x8 -> two entries buffered; pc_advance stays 0 for 0x8 until the first pop; order 0x0, 0x4, 0x8 preserved.
REQ-036 Flush in flight: flush=1 during WAIT for pc=0x10, ack arrives 2 cycles later -> no entry for 0x10; id_valid=0; the next issue uses the new pc.
REQ-037 Misaligned: pc=0x6 -> no imem_req; entry with id_pc=0x6, id_inst=0x0, id_misalign=1.
REQ-038 Reset mid-WAIT: rst=0 for 1 cycle while waiting, then ack -> all outputs 0, no entry pushed, FSM in IDLE.
REQ-039 Simultaneous pop, push and flush in one cycle -> count=0 next cycle, id_valid=0.
